axis_route_stamp: RTL
=====================

// Module: axis_route_stamp
// PURPOSE
//  Per-vFPGA ingress stage ahead of the 4-port data switch. One instance per region.
//  - Takes the user-logic output stream of its region and attaches tdest.
//  - Samples io_ctrl only at the first beat of a packet, so a routing change never splits a packet.
//  - Drops packets whose route is disabled; counts forwarded and dropped packets.
//  - Registered output with a 2-entry skid buffer; full throughput.
// PARAMETERS
//  DATA_BITS  AXI_DATA_BITS  tdata width; tkeep is DATA_BITS/8
//  ID_BITS    PID_BITS       tid width
//  DEST_BITS  2              tdest width; equals the switch port-select width
//  CNT_BITS   32             pkt_cnt / drop_cnt width
// PORTS
//  aclk           in   1            clock
//  aresetn        in   1            reset, synchronous, active-low
//  io_ctrl        in   8            [7] route enable, [DEST_BITS-1:0] destination port
//  s_axis_tvalid  in   1            input beat valid
//  s_axis_tready  out  1            input ready
//  s_axis_tdata   in   DATA_BITS    input data
//  s_axis_tkeep   in   DATA_BITS/8  input byte enables
//  s_axis_tlast   in   1            input end of packet
//  s_axis_tid     in   ID_BITS      input process id
//  m_axis_tvalid  out  1            output beat valid, to the switch slave port
//  m_axis_tready  in   1            output ready
//  m_axis_tdata   out  DATA_BITS    output data
//  m_axis_tkeep   out  DATA_BITS/8  output byte enables
//  m_axis_tlast   out  1            output end of packet
//  m_axis_tid     out  ID_BITS      output process id
//  m_axis_tdest   out  DEST_BITS    latched route
//  pkt_cnt        out  CNT_BITS     packets forwarded (counted on output tlast handshake)
//  drop_cnt       out  CNT_BITS     packets dropped (counted on dropped tlast)
//  busy           out  1            mid-packet (state != ST_IDLE) or skid buffer not empty
// BEHAVIOUR
//  Reset (aresetn==0 at posedge):
//   - state = ST_IDLE; skid buffer emptied; both counters = 0.
//   - m_axis_tvalid = 0; all m_axis_* data fields = 0.
//   - s_axis_tready = 0 while reset is asserted, 1 on the first cycle after release.
//   - A reset mid-packet abandons the packet; the downstream switch sees tvalid fall without tlast.
//  FSM states: ST_IDLE, ST_FWD, ST_DROP.
//   - ST_IDLE, first beat accepted: latch dest = io_ctrl[DEST_BITS-1:0] and en = io_ctrl[7].
//       en=1 and !tlast -> ST_FWD.  en=0 and !tlast -> ST_DROP.  tlast=1 -> stay ST_IDLE.
//   - ST_FWD: a beat with tlast accepted -> ST_IDLE.
//   - ST_DROP: a beat with tlast accepted -> ST_IDLE.
//   - io_ctrl changes while in ST_FWD or ST_DROP are ignored until the next first beat.
//   - A single-beat packet uses io_ctrl from its own cycle.
//  Forward path:
//   - Accept = s_axis_tvalid & s_axis_tready.
//   - Accepted beat appears on m_axis_* with tdest = latched dest, exactly 1 cycle later if the buffer was empty.
//   - s_axis_tready is a register: 1 when the skid buffer holds fewer than 2 entries' worth of
//     backlog (entry 0 = output register, entry 1 = skid). No combinational path from m_axis_tready.
//   - m_axis_* are held stable while tvalid=1 and tready=0 (AXIS rule). Beat order is preserved.
//  Drop path:
//   - In ST_DROP, or on an IDLE first beat with en=0: s_axis_tready = 1 regardless of
//     output backpressure; beats are discarded and never written to the buffer.
//   - An IDLE first beat with en=0 is accepted only if tready was already 1 (registered).
//  Counters:
//   - Free-running modulo 2^CNT_BITS; they wrap silently.
//   - pkt_cnt increments on m_axis_tvalid & m_axis_tready & m_axis_tlast.
//   - drop_cnt increments on the accept of a dropped beat with tlast.
//   - Both may increment in the same cycle.
//  Simultaneous events:
//   - Output pop and input push in the same cycle keep occupancy unchanged; no bubble, no loss.
// TESTING
//  T1 io_ctrl=8'h82, 4-beat packet, m_ready=1 -> 4 beats with tdest=2, 1-cycle latency, pkt_cnt=1.
//  T2 io_ctrl=8'h81; after beat 1 of an 8-beat packet set io_ctrl=8'h83 -> all 8 beats tdest=1;
//     the next packet gets tdest=3.
//  T3 io_ctrl=8'h00, 5-beat packet while m_ready=0 -> s_ready=1 every beat, m_valid stays 0,
//     drop_cnt=1, pkt_cnt=0.
//  T4 m_ready toggling with a random 50% pattern, 100 random-length packets -> data/tkeep/tid/tlast
//     match a scoreboard, no stalls beyond backpressure, pkt_cnt=100.
//  T5 back-to-back single-beat packets, io_ctrl cycling 0x80..0x83 each cycle -> beat k carries
//     tdest = k mod 4, 1 beat/cycle.
//  T6 assert aresetn=0 on beat 3 of 6 with m_ready=0 -> next cycle m_valid=0, counters=0, ST_IDLE;
//     a following 2-beat packet is forwarded correctly.

Source files
------------

// File: rtl/axis_route_stamp_if.sv
// AXI-Stream bundle used on both sides of the route-stamp stage.
// Upstream user logic carries no route, so tdest is only part of the master view.
interface axis_route_stamp_if #(
  parameter int DATA_BITS = 64,
  parameter int ID_BITS   = 6,
  parameter int DEST_BITS = 2
);
  logic                   tvalid;
  logic                   tready;
  logic [DATA_BITS-1:0]   tdata;
  logic [DATA_BITS/8-1:0] tkeep;
  logic                   tlast;
  logic [ID_BITS-1:0]     tid;
  logic [DEST_BITS-1:0]   tdest;

  modport master (output tvalid, tdata, tkeep, tlast, tid, tdest, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tid, output tready);
endinterface

// File: rtl/axis_route_stamp.sv
// Per-region ingress stage: stamps tdest from io_ctrl at the first beat of each packet,
// discards packets whose route is disabled, and forwards the rest through a 2-entry skid buffer.
module axis_route_stamp #(
  parameter int DATA_BITS = 64,
  parameter int ID_BITS   = 6,
  parameter int DEST_BITS = 2,
  parameter int CNT_BITS  = 32
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [7:0]           io_ctrl,
  axis_route_stamp_if.slave    s_axis,
  axis_route_stamp_if.master   m_axis,
  output logic [CNT_BITS-1:0]  pkt_cnt,
  output logic [CNT_BITS-1:0]  drop_cnt,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_BITS-1:0]   data;
    logic [DATA_BITS/8-1:0] keep;
    logic                   last;
    logic [ID_BITS-1:0]     id;
    logic [DEST_BITS-1:0]   dest;
  } beat_t;

  state_t               state_r, state_s;
  logic [DEST_BITS-1:0] dest_r, dest_s;
  beat_t                out_r, out_s, skid_r, skid_s, in_beat_s;
  logic                 out_valid_r, out_valid_s;
  logic                 skid_valid_r, skid_valid_s;
  logic                 s_ready_r, s_ready_s;
  logic                 busy_r, busy_s;
  logic [CNT_BITS-1:0]  pkt_cnt_r, drop_cnt_r;
  logic                 accept_s, first_s, fwd_beat_s, push_s;
  logic                 drop_last_s, pop_last_s, out_load_s;
  logic                 unused_ctrl_s;

  // Only the enable bit and the port select are meaningful in io_ctrl.
  assign unused_ctrl_s = ^io_ctrl[6:DEST_BITS];

  assign accept_s    = s_axis.tvalid & s_ready_r;
  assign first_s     = (state_r == ST_IDLE);
  assign fwd_beat_s  = (state_r == ST_FWD) | (first_s & io_ctrl[7]);
  assign push_s      = accept_s & fwd_beat_s;
  assign drop_last_s = accept_s & ~fwd_beat_s & s_axis.tlast;
  assign pop_last_s  = out_valid_r & m_axis.tready & out_r.last;
  assign out_load_s  = ~out_valid_r | m_axis.tready;

  // Packet-boundary FSM: route is captured only on the first accepted beat.
  always_comb begin
    state_s = state_r;
    dest_s  = dest_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          dest_s = io_ctrl[DEST_BITS-1:0];
          if (s_axis.tlast) begin
            state_s = ST_IDLE;
          end else if (io_ctrl[7]) begin
            state_s = ST_FWD;
          end else begin
            state_s = ST_DROP;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FWD: begin
        if (accept_s & s_axis.tlast) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_FWD;
        end
      end
      ST_DROP: begin
        if (accept_s & s_axis.tlast) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DROP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output register plus skid entry; a push never lands while the skid is occupied.
  always_comb begin
    in_beat_s.data = s_axis.tdata;
    in_beat_s.keep = s_axis.tkeep;
    in_beat_s.last = s_axis.tlast;
    in_beat_s.id   = s_axis.tid;
    in_beat_s.dest = first_s ? io_ctrl[DEST_BITS-1:0] : dest_r;
    out_s          = out_r;
    out_valid_s    = out_valid_r;
    skid_s         = skid_r;
    skid_valid_s   = skid_valid_r;
    if (out_load_s) begin
      if (skid_valid_r) begin
        out_s        = skid_r;
        out_valid_s  = 1'b1;
        skid_valid_s = 1'b0;
      end else if (push_s) begin
        out_s       = in_beat_s;
        out_valid_s = 1'b1;
      end else begin
        out_valid_s = 1'b0;
      end
    end else begin
      if (push_s) begin
        skid_s       = in_beat_s;
        skid_valid_s = 1'b1;
      end else begin
        skid_valid_s = skid_valid_r;
      end
    end
    // Dropping never touches the buffer, so it may ignore backpressure entirely.
    s_ready_s = (state_s == ST_DROP) | ~skid_valid_s;
    busy_s    = (state_s != ST_IDLE) | out_valid_s | skid_valid_s;
  end

  // State, buffer, ready, status and counter registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r      <= ST_IDLE;
      dest_r       <= '0;
      out_r        <= '0;
      skid_r       <= '0;
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      s_ready_r    <= 1'b0;
      busy_r       <= 1'b0;
      pkt_cnt_r    <= '0;
      drop_cnt_r   <= '0;
    end else begin
      state_r      <= state_s;
      dest_r       <= dest_s;
      out_r        <= out_s;
      skid_r       <= skid_s;
      out_valid_r  <= out_valid_s;
      skid_valid_r <= skid_valid_s;
      s_ready_r    <= s_ready_s;
      busy_r       <= busy_s;
      if (pop_last_s) begin
        pkt_cnt_r <= pkt_cnt_r + CNT_BITS'(1'b1);
      end
      if (drop_last_s) begin
        drop_cnt_r <= drop_cnt_r + CNT_BITS'(1'b1);
      end
    end
  end

  assign s_axis.tready = s_ready_r;
  assign m_axis.tvalid = out_valid_r;
  assign m_axis.tdata  = out_r.data;
  assign m_axis.tkeep  = out_r.keep;
  assign m_axis.tlast  = out_r.last;
  assign m_axis.tid    = out_r.id;
  assign m_axis.tdest  = out_r.dest;
  assign pkt_cnt       = pkt_cnt_r;
  assign drop_cnt      = drop_cnt_r;
  assign busy          = busy_r;

endmodule
